// File: rtl/sp_ram_arbiter.sv
// Two-port round-robin arbiter in front of the single-port SRAM wrapper.
// Zero-fills the array after reset, then shares it between ports A and B.
module sp_ram_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter bit INIT_EN    = 1'b1,
  parameter int INIT_WORDS = 8192
) (
  input  logic                    clk,
  input  logic                    rst_i,

  input  logic                    a_req_i,
  output logic                    a_gnt_o,
  output logic                    a_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   a_addr_i,
  input  logic                    a_we_i,
  input  logic [DATA_WIDTH/8-1:0] a_be_i,
  input  logic [DATA_WIDTH-1:0]   a_wdata_i,
  output logic [DATA_WIDTH-1:0]   a_rdata_o,

  input  logic                    b_req_i,
  output logic                    b_gnt_o,
  output logic                    b_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   b_addr_i,
  input  logic                    b_we_i,
  input  logic [DATA_WIDTH/8-1:0] b_be_i,
  input  logic [DATA_WIDTH-1:0]   b_wdata_i,
  output logic [DATA_WIDTH-1:0]   b_rdata_o,

  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i,

  output logic                    init_done_o
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int CW = (INIT_WORDS > 1) ? $clog2(INIT_WORDS) : 1;

  typedef enum logic { S_INIT, S_RUN } state_e;
  typedef enum logic { RR_A, RR_B } rr_e;

  state_e          state_q, state_d;
  rr_e             rr_q, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            a_rvalid_q, b_rvalid_q;

  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  cnt_last;

  assign init_addr = ADDR_WIDTH'({cnt_q, 2'b00});
  assign cnt_last  = (cnt_q == CW'(INIT_WORDS - 1));

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    a_gnt_o     = 1'b0;
    b_gnt_o     = 1'b0;
    ram_en_o    = 1'b0;
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_wdata_o = '0;

    unique case (state_q)
      S_INIT: begin
        ram_en_o    = 1'b1;
        ram_we_o    = 1'b1;
        ram_be_o    = {BW{1'b1}};
        ram_addr_o  = init_addr;
        cnt_d       = cnt_q + CW'(1);
        if (cnt_last) begin
          state_d = S_RUN;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        // On contention rr picks the winner; a lone requester always wins.
        if (a_req_i && (!b_req_i || rr_q == RR_A)) begin
          a_gnt_o     = 1'b1;
          ram_en_o    = 1'b1;
          ram_addr_o  = a_addr_i;
          ram_we_o    = a_we_i;
          ram_be_o    = a_we_i ? a_be_i : {BW{1'b1}};
          ram_wdata_o = a_wdata_i;
          rr_d        = RR_B;
        end else if (b_req_i) begin
          b_gnt_o     = 1'b1;
          ram_en_o    = 1'b1;
          ram_addr_o  = b_addr_i;
          ram_we_o    = b_we_i;
          ram_be_o    = b_we_i ? b_be_i : {BW{1'b1}};
          ram_wdata_o = b_wdata_i;
          rr_d        = RR_A;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q    <= INIT_EN ? S_INIT : S_RUN;
      rr_q       <= RR_A;
      cnt_q      <= '0;
      done_q     <= ~INIT_EN;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      a_rvalid_q <= a_gnt_o;
      b_rvalid_q <= b_gnt_o;
    end
  end

  assign a_rvalid_o  = a_rvalid_q;
  assign b_rvalid_o  = b_rvalid_q;
  assign a_rdata_o   = ram_rdata_i;
  assign b_rdata_o   = ram_rdata_i;
  assign init_done_o = done_q;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter with a behavioural SRAM model.
// A second instance covers the no-init configuration.
module tb_sp_ram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  logic        a_req, a_gnt, a_rvalid, a_we;
  logic [14:0] a_addr;
  logic [3:0]  a_be;
  logic [31:0] a_wdata, a_rdata;
  logic        b_req, b_gnt, b_rvalid, b_we;
  logic [14:0] b_addr;
  logic [3:0]  b_be;
  logic [31:0] b_wdata, b_rdata;
  logic        ram_en, ram_we, init_done;
  logic [14:0] ram_addr;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata, ram_rdata;

  sp_ram_arbiter dut (
    .clk(clk), .rst_i(rst),
    .a_req_i(a_req), .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid),
    .a_addr_i(a_addr), .a_we_i(a_we), .a_be_i(a_be),
    .a_wdata_i(a_wdata), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid),
    .b_addr_i(b_addr), .b_we_i(b_we), .b_be_i(b_be),
    .b_wdata_i(b_wdata), .b_rdata_o(b_rdata),
    .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_we_o(ram_we),
    .ram_be_o(ram_be), .ram_wdata_o(ram_wdata),
    .ram_rdata_i(ram_rdata), .init_done_o(init_done)
  );

  logic [31:0] mem [0:8191];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int k = 0; k < 4; k++)
          if (ram_be[k]) mem[ram_addr[14:2]][8*k +: 8] <= ram_wdata[8*k +: 8];
      end
      ram_rdata <= mem[ram_addr[14:2]];
    end
  end

  logic        a2_req = 1'b1;
  logic        a2_gnt, a2_rvalid, b2_gnt, b2_rvalid;
  logic        r2_en, r2_we, d2_done;
  logic [14:0] r2_addr;
  logic [3:0]  r2_be;
  logic [31:0] r2_wdata, a2_rdata, b2_rdata;

  sp_ram_arbiter #(.INIT_EN(1'b0)) dut2 (
    .clk(clk), .rst_i(rst),
    .a_req_i(a2_req), .a_gnt_o(a2_gnt), .a_rvalid_o(a2_rvalid),
    .a_addr_i(15'h0000), .a_we_i(1'b0), .a_be_i(4'h0),
    .a_wdata_i(32'h0), .a_rdata_o(a2_rdata),
    .b_req_i(1'b0), .b_gnt_o(b2_gnt), .b_rvalid_o(b2_rvalid),
    .b_addr_i(15'h0000), .b_we_i(1'b0), .b_be_i(4'h0),
    .b_wdata_i(32'h0), .b_rdata_o(b2_rdata),
    .ram_en_o(r2_en), .ram_addr_o(r2_addr), .ram_we_o(r2_we),
    .ram_be_o(r2_be), .ram_wdata_o(r2_wdata),
    .ram_rdata_i(32'h0BADF00D), .init_done_o(d2_done)
  );

  // Walks n sweep cycles from word 0, counting any cycle that deviates.
  task automatic sweep(input int n, output int bad);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_be !== 4'hF ||
          ram_wdata !== 32'h0 || ram_addr !== 15'(i * 4) ||
          a_gnt !== 1'b0 || b_gnt !== 1'b0 || init_done !== 1'b0)
        bad++;
    end
  endtask

  initial begin
    @(negedge rst);
    @(negedge clk);
    chk("d2_done", d2_done, 1'b1);
    chk("d2_gnt", a2_gnt, 1'b1);
    chk("d2_addr", r2_addr, 15'h0000);
    @(posedge clk); #1;
    a2_req = 1'b0;
    chk("d2_rvalid", a2_rvalid, 1'b1);
    chk("d2_rdata", a2_rdata, 32'h0BADF00D);
    @(posedge clk); #1;
    chk("d2_rvalid_off", a2_rvalid, 1'b0);
  end

  initial begin
    int bad;
    int nz;
    logic exp_a;
    for (int i = 0; i < 8192; i++) mem[i] = 32'hA5A5A5A5;
    a_req = 1'b1; a_we = 1'b0; a_addr = 15'h0; a_be = 4'h0; a_wdata = 32'h0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 15'h0; b_be = 4'h0; b_wdata = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", init_done, 1'b0);
    chk("rst_rvalid", a_rvalid, 1'b0);
    chk("rst_gnt", a_gnt, 1'b0);
    rst = 1'b0;

    sweep(8192, bad);
    chk("sweep1", bad, 0);
    @(posedge clk); #1;
    chk("done_rise", init_done, 1'b1);
    nz = 0;
    for (int i = 0; i < 8192; i++) if (mem[i] !== 32'h0) nz++;
    chk("mem_clear", nz, 0);

    @(negedge clk);
    chk("held_gnt", a_gnt, 1'b1);
    chk("held_be", ram_be, 4'hF);
    @(posedge clk); #1;
    a_req = 1'b0;
    chk("held_rvalid", a_rvalid, 1'b1);
    chk("held_rdata", a_rdata, 32'h0);

    a_req = 1'b1; a_we = 1'b1; a_addr = 15'h0104;
    a_be = 4'hF; a_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("aw_gnt", a_gnt, 1'b1);
    chk("aw_addr", ram_addr, 15'h0104);
    chk("aw_wdata", ram_wdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    a_we = 1'b0; a_be = 4'h0;
    chk("aw_rvalid", a_rvalid, 1'b1);
    @(negedge clk);
    chk("ar_gnt", a_gnt, 1'b1);
    chk("ar_be_force", ram_be, 4'hF);
    chk("ar_we", ram_we, 1'b0);
    @(posedge clk); #1;
    a_req = 1'b0;
    chk("ar_rvalid", a_rvalid, 1'b1);
    chk("ar_rdata", a_rdata, 32'hDEADBEEF);

    b_req = 1'b1; b_we = 1'b1; b_addr = 15'h7FFC;
    b_be = 4'b0101; b_wdata = 32'h11223344;
    @(negedge clk);
    chk("bw_gnt", b_gnt, 1'b1);
    chk("bw_be", ram_be, 4'b0101);
    @(posedge clk); #1;
    b_we = 1'b0; b_be = 4'h0;
    chk("bw_rvalid", b_rvalid, 1'b1);
    chk("bw_a_rvalid", a_rvalid, 1'b0);
    @(negedge clk);
    chk("br_gnt", b_gnt, 1'b1);
    @(posedge clk); #1;
    b_req = 1'b0;
    chk("br_rvalid", b_rvalid, 1'b1);
    chk("br_rdata", b_rdata, 32'h00220044);

    a_req = 1'b1; a_addr = 15'h0104;
    b_req = 1'b1; b_addr = 15'h7FFC;
    for (int i = 0; i < 6; i++) begin
      exp_a = (i % 2 == 0);
      @(negedge clk);
      chk("rr_a_gnt", a_gnt, exp_a);
      chk("rr_b_gnt", b_gnt, !exp_a);
      chk("rr_addr", ram_addr, exp_a ? 15'h0104 : 15'h7FFC);
      @(posedge clk); #1;
      chk("rr_a_rvalid", a_rvalid, exp_a);
      chk("rr_b_rvalid", b_rvalid, !exp_a);
      chk("rr_rdata", a_rdata, exp_a ? 32'hDEADBEEF : 32'h00220044);
    end
    b_req = 1'b0;

    rst = 1'b1;
    @(negedge clk);
    chk("rst_run_gnt", a_gnt, 1'b1);
    @(posedge clk); #1;
    chk("rst_drop_rvalid", a_rvalid, 1'b0);
    chk("rst_done2", init_done, 1'b0);
    rst = 1'b0;
    sweep(100, bad);
    chk("sweep_part", bad, 0);
    @(posedge clk); #1;
    chk("sweep_at100", ram_addr, 15'(100 * 4));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("restart_cnt0", ram_addr, 15'h0000);
    sweep(8192, bad);
    chk("sweep2", bad, 0);
    @(posedge clk); #1;
    chk("done_rise2", init_done, 1'b1);
    a_req = 1'b0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
